cmp_share_arbiter: RTL and testbench

//  Shares one Comparator_32bit cell (result = m >= n, unsigned) between two requesters
//  (e.g. branch unit and SLT/SLTU path) and sequences it to evaluate RV32I branch conditions.

---
 rtl/cmp_share_arbiter_pkg.sv | 48 ++++
 rtl/cmp_share_arbiter_arb.sv | 35 +++
 rtl/cmp_share_arbiter_cmp.sv | 12 +
 rtl/cmp_share_arbiter.sv | 146 ++++++++++++++
 tb/tb_cmp_share_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmp_share_arbiter_pkg.sv
// Shared types and op-code helpers for the two-requester comparator sharing arbiter.
package cmp_share_arbiter_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREQ = 2;
  localparam int unsigned OPW  = 3;

  localparam logic [OPW-1:0] OP_EQ  = 3'b000;
  localparam logic [OPW-1:0] OP_NE  = 3'b001;
  localparam logic [OPW-1:0] OP_LT  = 3'b100;
  localparam logic [OPW-1:0] OP_GE  = 3'b101;
  localparam logic [OPW-1:0] OP_LTU = 3'b110;
  localparam logic [OPW-1:0] OP_GEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP1 = 2'd1,
    ST_CMP2 = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic [OPW-1:0]  op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } req_t;

  // 010 and 011 are the only holes in the funct3 space we accept.
  function automatic logic op_legal(input logic [OPW-1:0] op);
    return op[2] | ~op[1];
  endfunction

  // EQ/NE compare in unsigned form, so only LT/GE need the MSB flip.
  function automatic logic op_signed(input logic [OPW-1:0] op);
    return op[2] & ~op[1];
  endfunction

  function automatic logic op_two_pass(input logic [OPW-1:0] op);
    return ~op[2];
  endfunction

  function automatic logic op_taken(input logic [OPW-1:0] op, input logic ge_ab,
                                    input logic ge_ba);
    if (op[2]) return op[0] ? ge_ab : ~ge_ab;
    return op[0] ^ (ge_ab & ge_ba);
  endfunction

endpackage

// File: rtl/cmp_share_arbiter_arb.sv
// Two-way grant with round-robin or fixed-priority tie-break and a last-grant register.
module cmp_share_arbiter_arb
  import cmp_share_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] valid,
  input  logic            accept,
  output logic [NREQ-1:0] grant_c
);

  logic last_grant;

  always_comb begin
    grant_c = 2'b00;
    case (valid)
      2'b01:   grant_c = 2'b01;
      2'b10:   grant_c = 2'b10;
      2'b11:   grant_c = (RR_EN && !last_grant) ? 2'b10 : 2'b01;
      default: grant_c = 2'b00;
    endcase
  end

  // Reset to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant_c[1];
    end
  end

endmodule

// File: rtl/cmp_share_arbiter_cmp.sv
// Shared 32-bit unsigned magnitude comparator: ge_c = (m >= n).
module cmp_share_arbiter_cmp
  import cmp_share_arbiter_pkg::*;
(
  input  logic [XLEN-1:0] m,
  input  logic [XLEN-1:0] n,
  output logic            ge_c
);

  assign ge_c = (m >= n);

endmodule

// File: rtl/cmp_share_arbiter.sv
// Arbitrates two branch-condition requesters onto one comparator and sequences 1-2 passes.
module cmp_share_arbiter
  import cmp_share_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [5:0]       req_op,
  input  logic [63:0]      req_a,
  input  logic [63:0]      req_b,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic             rsp_taken,
  output logic             rsp_err,
  output logic             busy
);

  state_t          state;
  req_t            cur;
  logic            gsel;
  logic            ge_ab;
  logic [1:0]      grant_c;
  logic            accept_c;
  req_t            in_c;
  logic [XLEN-1:0] a_x;
  logic [XLEN-1:0] b_x;
  logic [XLEN-1:0] cmp_m;
  logic [XLEN-1:0] cmp_n;
  logic            cmp_ge;

  cmp_share_arbiter_arb #(.RR_EN(RR_EN)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (req_valid),
    .accept  (accept_c),
    .grant_c (grant_c)
  );

  cmp_share_arbiter_cmp u_cmp (
    .m    (cmp_m),
    .n    (cmp_n),
    .ge_c (cmp_ge)
  );

  assign req_ready = (state == ST_IDLE) ? grant_c : 2'b00;
  assign accept_c  = |(req_valid & req_ready);

  always_comb begin
    in_c = '0;
    if (grant_c[1]) begin
      in_c.op = req_op[5:3];
      in_c.a  = req_a[63:32];
      in_c.b  = req_b[63:32];
    end else begin
      in_c.op = req_op[2:0];
      in_c.a  = req_a[31:0];
      in_c.b  = req_b[31:0];
    end
  end

  // Operand conditioning; the comparator sees zeros whenever it is not in use.
  always_comb begin
    a_x   = cur.a;
    b_x   = cur.b;
    cmp_m = '0;
    cmp_n = '0;
    if (op_signed(cur.op)) begin
      a_x[XLEN-1] = ~cur.a[XLEN-1];
      b_x[XLEN-1] = ~cur.b[XLEN-1];
    end
    case (state)
      ST_CMP1: begin
        cmp_m = a_x;
        cmp_n = b_x;
      end
      ST_CMP2: begin
        cmp_m = b_x;
        cmp_n = a_x;
      end
      default: begin
        cmp_m = '0;
        cmp_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cur       <= '0;
      gsel      <= 1'b0;
      ge_ab     <= 1'b0;
      rsp_valid <= 2'b00;
      rsp_taken <= 1'b0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            cur  <= in_c;
            gsel <= grant_c[1];
            busy <= 1'b1;
            if (op_legal(in_c.op)) begin
              state <= ST_CMP1;
            end else begin
              state     <= ST_RESP;
              rsp_valid <= grant_c;
              rsp_taken <= 1'b0;
              rsp_err   <= 1'b1;
            end
          end
        end
        ST_CMP1: begin
          ge_ab <= cmp_ge;
          if (op_two_pass(cur.op)) begin
            state <= ST_CMP2;
          end else begin
            state     <= ST_RESP;
            rsp_valid <= {gsel, ~gsel};
            rsp_taken <= op_taken(cur.op, cmp_ge, 1'b0);
          end
        end
        ST_CMP2: begin
          state     <= ST_RESP;
          rsp_valid <= {gsel, ~gsel};
          rsp_taken <= op_taken(cur.op, ge_ab, cmp_ge);
        end
        ST_RESP: begin
          if (rsp_ready[gsel]) begin
            state     <= ST_IDLE;
            rsp_valid <= 2'b00;
            rsp_taken <= 1'b0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Self-checking bench for cmp_share_arbiter against a plain-arithmetic reference model.
module tb_cmp_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [5:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic        rsp_taken;
  logic        rsp_err;
  logic        busy;

  logic [1:0]  fp_req_valid;
  logic [1:0]  fp_req_ready;
  logic [1:0]  fp_rsp_valid;
  logic [1:0]  fp_rsp_ready;
  logic        fp_rsp_taken;
  logic        fp_rsp_err;
  logic        fp_busy;

  int errors;
  int checks;
  int model_last;

  cmp_share_arbiter #(.RR_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_taken (rsp_taken),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  cmp_share_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (fp_req_valid),
    .req_ready (fp_req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (fp_rsp_valid),
    .rsp_ready (fp_rsp_ready),
    .rsp_taken (fp_rsp_taken),
    .rsp_err   (fp_rsp_err),
    .busy      (fp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: branch condition from the op meaning, plus expected response latency.
  function automatic void ref_eval(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic tk,
                                   output logic er, output int lat);
    er  = 1'b0;
    lat = 2;
    case (op)
      3'b000:  begin tk = (a == b); lat = 3; end
      3'b001:  begin tk = (a != b); lat = 3; end
      3'b100:  tk = ($signed(a) <  $signed(b));
      3'b101:  tk = ($signed(a) >= $signed(b));
      3'b110:  tk = (a <  b);
      3'b111:  tk = (a >= b);
      default: begin tk = 1'b0; er = 1'b1; lat = 1; end
    endcase
  endfunction

  task automatic set_lane(input int g, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    req_op[g*3 +: 3]  = op;
    req_a[g*32 +: 32] = a;
    req_b[g*32 +: 32] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1;
    @(posedge clk);
    #1;
  endtask

  // One request/response exchange; must be entered just after a rising edge.
  task automatic txn(input logic [1:0] vmask, input int hold, input bit raise_other,
                     output int got_g, output logic got_tk);
    int eg;
    int elat;
    int n;
    logic [2:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic etk;
    logic eer;
    logic [1:0] oh;
    logic [1:0] ot;
    if (vmask == 2'b11) eg = (model_last == 0) ? 1 : 0;
    else eg = vmask[1] ? 1 : 0;
    op = req_op[eg*3 +: 3];
    a  = req_a[eg*32 +: 32];
    b  = req_b[eg*32 +: 32];
    ref_eval(op, a, b, etk, eer, elat);
    oh = (eg == 1) ? 2'b10 : 2'b01;
    ot = ~oh;
    req_valid = vmask;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL idle_state: busy=%b rsp_valid=%b required busy=0 rsp_valid=00", busy, rsp_valid);
    end
    checks++;
    if (req_ready !== oh) begin
      errors++;
      $display("FAIL grant: req_ready=%b required %b (valid=%b)", req_ready, oh, vmask);
    end
    @(posedge clk);
    #1;
    req_valid[eg] = 1'b0;
    model_last = eg;
    if (raise_other) req_valid = req_valid | ot;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid == 2'b00 && n < 8);
    checks++;
    if (n !== elat) begin
      errors++;
      $display("FAIL latency: op=%b got %0d cycles required %0d", op, n, elat);
    end
    checks++;
    if ({rsp_valid, rsp_taken, rsp_err} !== {oh, etk, eer}) begin
      errors++;
      $display("FAIL response: op=%b a=%h b=%h got valid=%b taken=%b err=%b required valid=%b taken=%b err=%b",
               op, a, b, rsp_valid, rsp_taken, rsp_err, oh, etk, eer);
    end
    got_g  = rsp_valid[1] ? 1 : 0;
    got_tk = rsp_taken;
    for (int h = 0; h <= hold; h++) begin
      checks++;
      if (rsp_valid !== oh || rsp_taken !== etk || rsp_err !== eer || busy !== 1'b1 ||
          req_ready !== 2'b00 || dut.cmp_m !== 32'd0 || dut.cmp_n !== 32'd0) begin
        errors++;
        $display("FAIL resp_hold: cycle %0d valid=%b taken=%b err=%b busy=%b req_ready=%b m=%h n=%h required valid=%b taken=%b err=%b busy=1 req_ready=00 m=n=0",
                 h, rsp_valid, rsp_taken, rsp_err, busy, req_ready, dut.cmp_m, dut.cmp_n,
                 oh, etk, eer);
      end
      if (h < hold) begin
        rsp_ready = ot;
        @(negedge clk);
      end
    end
    rsp_ready = oh;
    @(posedge clk);
    #1;
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({req_ready, rsp_valid, rsp_taken, rsp_err, busy} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0000000",
               {req_ready, rsp_valid, rsp_taken, rsp_err, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1;
    @(posedge clk);
    #1;
    checks++;
    if ({rsp_valid, rsp_taken, rsp_err, busy} !== 5'd0) begin
      errors++;
      $display("FAIL post_reset: got %b required 00000", {rsp_valid, rsp_taken, rsp_err, busy});
    end
  endtask

  task automatic test_geu();
    int g;
    logic tk;
    set_lane(0, 3'b111, 32'd5, 32'd5);
    txn(2'b01, 0, 1'b0, g, tk);
    checks++;
    if (g !== 0 || tk !== 1'b1) begin
      errors++;
      $display("FAIL geu_5_5: grant=%0d taken=%b required 0/1", g, tk);
    end
  endtask

  task automatic test_signed();
    int g;
    logic tk;
    set_lane(1, 3'b100, 32'hFFFF_FFFF, 32'd1);
    txn(2'b10, 0, 1'b0, g, tk);
    checks++;
    if (g !== 1 || tk !== 1'b1) begin
      errors++;
      $display("FAIL lt_neg1_1: grant=%0d taken=%b required 1/1", g, tk);
    end
    set_lane(1, 3'b110, 32'hFFFF_FFFF, 32'd1);
    txn(2'b10, 0, 1'b0, g, tk);
    checks++;
    if (g !== 1 || tk !== 1'b0) begin
      errors++;
      $display("FAIL ltu_max_1: grant=%0d taken=%b required 1/0", g, tk);
    end
  endtask

  task automatic test_priority();
    int g;
    logic tk;
    int exp_seq [4] = '{0, 1, 0, 1};
    logic [1:0] masks [4] = '{2'b11, 2'b11, 2'b11, 2'b10};
    do_reset();
    set_lane(0, 3'b000, 32'd7, 32'd7);
    set_lane(1, 3'b000, 32'd7, 32'd7);
    for (int i = 0; i < 4; i++) begin
      txn(masks[i], 0, 1'b0, g, tk);
      checks++;
      if (g !== exp_seq[i] || tk !== 1'b1) begin
        errors++;
        $display("FAIL rr_order: step %0d grant=%0d taken=%b required %0d/1", i, g, tk, exp_seq[i]);
      end
    end
  endtask

  task automatic test_illegal();
    int g;
    logic tk;
    set_lane(0, 3'b010, $urandom, $urandom);
    txn(2'b01, 1, 1'b0, g, tk);
    checks++;
    if (g !== 0 || tk !== 1'b0) begin
      errors++;
      $display("FAIL illegal_op: grant=%0d taken=%b required 0/0", g, tk);
    end
  endtask

  task automatic test_hold();
    int g;
    logic tk;
    set_lane(0, 3'b001, 32'h8000_0000, 32'h7FFF_FFFF);
    set_lane(1, 3'b101, 32'd3, 32'd3);
    txn(2'b01, 5, 1'b1, g, tk);
    checks++;
    if (g !== 0 || tk !== 1'b1) begin
      errors++;
      $display("FAIL ne_hold: grant=%0d taken=%b required 0/1", g, tk);
    end
    txn(2'b10, 0, 1'b0, g, tk);
    checks++;
    if (g !== 1 || tk !== 1'b1) begin
      errors++;
      $display("FAIL pending_req1: grant=%0d taken=%b required 1/1", g, tk);
    end
  endtask

  task automatic test_fixed_prio();
    int hits0;
    int hits1;
    hits0 = 0;
    hits1 = 0;
    set_lane(0, 3'b000, 32'd7, 32'd7);
    set_lane(1, 3'b000, 32'd7, 32'd7);
    fp_req_valid = 2'b11;
    fp_rsp_ready = 2'b11;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fp_rsp_valid[0]) hits0++;
      if (fp_rsp_valid[1] || fp_req_ready[1]) hits1++;
    end
    checks++;
    if (hits1 !== 0) begin
      errors++;
      $display("FAIL fixed_prio_req1: req1 activity %0d cycles required 0", hits1);
    end
    checks++;
    if (hits0 < 5) begin
      errors++;
      $display("FAIL fixed_prio_req0: req0 responses %0d required >= 5", hits0);
    end
    fp_req_valid = 2'b00;
    repeat (5) @(negedge clk);
    fp_rsp_ready = 2'b00;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int g;
    logic tk;
    int seen;
    set_lane(0, 3'b000, 32'd9, 32'd9);
    req_valid = 2'b01;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rm_accept: req_ready=%b required 01", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL rm_in_cmp2: busy=%b rsp_valid=%b required 1/00", busy, rsp_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_taken, rsp_err, busy} !== 7'd0) begin
      errors++;
      $display("FAIL rm_async_clear: got %b required 0000000",
               {req_ready, rsp_valid, rsp_taken, rsp_err, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rm_no_response: activity on %0d cycles required 0", seen);
    end
    @(posedge clk);
    #1;
    set_lane(0, 3'b000, 32'd7, 32'd7);
    set_lane(1, 3'b000, 32'd4, 32'd5);
    txn(2'b11, 0, 1'b0, g, tk);
    checks++;
    if (g !== 0 || tk !== 1'b1) begin
      errors++;
      $display("FAIL rm_reissue0: grant=%0d taken=%b required 0/1", g, tk);
    end
    txn(2'b10, 0, 1'b0, g, tk);
    checks++;
    if (g !== 1 || tk !== 1'b0) begin
      errors++;
      $display("FAIL rm_reissue1: grant=%0d taken=%b required 1/0", g, tk);
    end
  endtask

  task automatic test_random();
    bit pending [2];
    int g;
    logic tk;
    logic [31:0] a;
    logic [31:0] b;
    int mode;
    pending[0] = 1'b0;
    pending[1] = 1'b0;
    for (int it = 0; it < 60; it++) begin
      for (int l = 0; l < 2; l++) begin
        if (!pending[l] && ($urandom_range(0, 1) == 1 || (!pending[0] && !pending[1] && l == 1))) begin
          a = $urandom;
          mode = $urandom_range(0, 2);
          b = (mode == 0) ? a : (mode == 1) ? $urandom : (a ^ 32'h8000_0000);
          set_lane(l, 3'($urandom_range(0, 7)), a, b);
          pending[l] = 1'b1;
        end
      end
      txn({pending[1], pending[0]}, $urandom_range(0, 3), 1'b0, g, tk);
      pending[g] = 1'b0;
    end
    req_valid = 2'b00;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    model_last = 1;
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    fp_req_valid = 2'b00;
    fp_rsp_ready = 2'b00;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    test_reset();
    test_geu();
    test_signed();
    test_priority();
    test_illegal();
    test_hold();
    test_fixed_prio();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
